// File: rtl/id_ex_issue.sv
// id_ex_issue: ID/EX pipeline register with EX-side operand forwarding and load-use stall detection
// Ports: clk/rst_n (sync active-low); hold freezes all state; flush squashes the next EX slot;
//   id_* decoded instruction from ID; fw_m_*/fw_w_* EX/MEM and MEM/WB bypass sources;
//   load_stall (comb.) asks the front end to hold; ex_*/alu_* registered EX-stage outputs
//   with forwarded operands; stall_cnt counts load-use stall cycles, saturating.
module id_ex_issue #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [2:0]        id_aluctr,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [31:0]       id_rs_val,
  input  logic [31:0]       id_rt_val,
  input  logic [31:0]       id_imm,
  input  logic              id_alusrc,
  input  logic              id_shsel,
  input  logic [3:0]        id_ctl,
  input  logic              fw_m_wr,
  input  logic [REG_AW-1:0] fw_m_rd,
  input  logic [31:0]       fw_m_val,
  input  logic              fw_w_wr,
  input  logic [REG_AW-1:0] fw_w_rd,
  input  logic [31:0]       fw_w_val,
  output logic              load_stall,
  output logic              ex_valid,
  output logic [2:0]        alu_ctr,
  output logic [31:0]       alu_a,
  output logic [31:0]       alu_b,
  output logic [REG_AW-1:0] ex_rd,
  output logic [3:0]        ex_ctl,
  output logic [31:0]       ex_store,
  output logic [CNT_W-1:0]  stall_cnt
);
  typedef struct packed {
    logic              valid;
    logic [2:0]        aluctr;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    logic [31:0]       rs_val;
    logic [31:0]       rt_val;
    logic [31:0]       imm;
    logic              alusrc;
    logic              shsel;
    logic [3:0]        ctl;
  } ex_t;

  ex_t ex;
  logic [31:0] fwd_rs, fwd_rt;

  // $0 is never forwarded; EX/MEM is younger so it wins over MEM/WB
  function automatic logic [31:0] fwd(input logic [REG_AW-1:0] s, input logic [31:0] v);
    return (s == '0) ? v :
           (fw_m_wr && fw_m_rd == s) ? fw_m_val :
           (fw_w_wr && fw_w_rd == s) ? fw_w_val : v;
  endfunction

  // both sources compared regardless of use; the bubble that follows clears this
  assign load_stall = ex.valid && ex.ctl[2] && ex.rd != '0 && id_valid &&
                      (ex.rd == id_rs || ex.rd == id_rt);

  always_ff @(posedge clk)
    if (!rst_n) begin
      ex        <= '0;
      stall_cnt <= '0;
    end else if (!hold) begin
      if (load_stall && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
      ex <= (flush || load_stall) ? '0 :
            '{id_valid, id_aluctr, id_rs, id_rt, id_rd, id_rs_val, id_rt_val, id_imm,
              id_alusrc, id_shsel, id_ctl & {4{id_valid}}};
    end

  assign fwd_rs   = fwd(ex.rs, ex.rs_val);
  assign fwd_rt   = fwd(ex.rt, ex.rt_val);
  assign alu_a    = ex.shsel ? {27'b0, ex.imm[10:6]} : fwd_rs;
  assign alu_b    = ex.alusrc ? ex.imm : fwd_rt;
  assign ex_store = fwd_rt;
  assign ex_valid = ex.valid;
  assign alu_ctr  = ex.aluctr;
  assign ex_rd    = ex.rd;
  assign ex_ctl   = ex.ctl;
endmodule

// File: tb/tb_id_ex_issue.sv
// tb_id_ex_issue: directed vector bench for id_ex_issue (CNT_W=2 to reach saturation)
module tb_id_ex_issue;
  logic clk = 0, rst_n = 0, hold = 0, flush = 0, id_valid = 0, id_alusrc = 0, id_shsel = 0;
  logic [2:0] id_aluctr = 0;
  logic [4:0] id_rs = 0, id_rt = 0, id_rd = 0, fw_m_rd = 0, fw_w_rd = 0;
  logic [31:0] id_rs_val = 0, id_rt_val = 0, id_imm = 0, fw_m_val = 0, fw_w_val = 0;
  logic [3:0] id_ctl = 0;
  logic fw_m_wr = 0, fw_w_wr = 0;
  logic load_stall, ex_valid;
  logic [2:0] alu_ctr;
  logic [31:0] alu_a, alu_b, ex_store;
  logic [4:0] ex_rd;
  logic [3:0] ex_ctl;
  logic [1:0] stall_cnt;
  int total = 0, bad = 0;
  int exp_cnt = 0;

  id_ex_issue #(.REG_AW(5), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush), .id_valid(id_valid),
    .id_aluctr(id_aluctr), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rs_val(id_rs_val), .id_rt_val(id_rt_val), .id_imm(id_imm),
    .id_alusrc(id_alusrc), .id_shsel(id_shsel), .id_ctl(id_ctl),
    .fw_m_wr(fw_m_wr), .fw_m_rd(fw_m_rd), .fw_m_val(fw_m_val),
    .fw_w_wr(fw_w_wr), .fw_w_rd(fw_w_rd), .fw_w_val(fw_w_val),
    .load_stall(load_stall), .ex_valid(ex_valid), .alu_ctr(alu_ctr),
    .alu_a(alu_a), .alu_b(alu_b), .ex_rd(ex_rd), .ex_ctl(ex_ctl),
    .ex_store(ex_store), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string nm;
    logic valid; logic [2:0] aluctr; logic [4:0] rs, rt, rd;
    logic [31:0] rsv, rtv, imm; logic alusrc, shsel; logic [3:0] ctl;
    logic mwr; logic [4:0] mrd; logic [31:0] mval;
    logic wwr; logic [4:0] wrd; logic [31:0] wval;
    logic [31:0] ea, eb, es; logic [3:0] ectl;
  } vec_t;
  vec_t v[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic val, input logic [2:0] ac, input logic [4:0] rs, rt, rd,
                        input logic [31:0] rsv, rtv, imm, input logic as, ss, input logic [3:0] ctl);
    id_valid = val; id_aluctr = ac; id_rs = rs; id_rt = rt; id_rd = rd;
    id_rs_val = rsv; id_rt_val = rtv; id_imm = imm; id_alusrc = as; id_shsel = ss; id_ctl = ctl;
  endtask

  task automatic set_fw(input logic mw, input logic [4:0] mr, input logic [31:0] mv,
                        input logic ww, input logic [4:0] wr, input logic [31:0] wv);
    fw_m_wr = mw; fw_m_rd = mr; fw_m_val = mv; fw_w_wr = ww; fw_w_rd = wr; fw_w_val = wv;
  endtask

  // lw r8 captured into EX, then ID presents an add reading r8
  task automatic lw_then_use;
    set_fw(0, 0, 0, 0, 0, 0);
    set_id(1, 3'b000, 5'd1, 5'd2, 5'd8, 32'h1, 32'h2, 32'h0, 0, 0, 4'b1101);
    tick;
    set_id(1, 3'b000, 5'd8, 5'd0, 5'd9, 32'hDEAD, 32'h0, 32'h0, 0, 0, 4'b1000);
    #1;
  endtask

  initial begin
    v[0] = '{"fw_m_wins", 1, 3'b000, 5, 6, 1, 32'h1, 32'h2, 0, 0, 0, 4'b1000,
             1, 5, 32'h11, 1, 5, 32'h22, 32'h11, 32'h2, 32'h2, 4'b1000};
    v[1] = '{"fw_w_only", 1, 3'b001, 5, 6, 2, 32'h1, 32'h2, 0, 0, 0, 4'b1000,
             0, 5, 32'h11, 1, 5, 32'h22, 32'h22, 32'h2, 32'h2, 4'b1000};
    v[2] = '{"zero_reg", 1, 3'b011, 0, 7, 3, 32'h33, 32'h4, 0, 0, 0, 4'b1000,
             1, 0, 32'h11, 1, 0, 32'h22, 32'h33, 32'h4, 32'h4, 4'b1000};
    v[3] = '{"sll_shamt", 1, 3'b010, 2, 3, 4, 32'h9, 32'h3, 32'h100, 0, 1, 4'b1000,
             0, 0, 0, 0, 0, 0, 32'h4, 32'h3, 32'h3, 4'b1000};
    v[4] = '{"addi_imm", 1, 3'b000, 1, 4, 4, 32'h7, 32'h7, 32'hFFFFFFFF, 1, 0, 4'b1000,
             1, 4, 32'h55, 0, 0, 0, 32'h7, 32'hFFFFFFFF, 32'h55, 4'b1000};
    v[5] = '{"fw_w_rt", 1, 3'b110, 1, 9, 5, 32'h10, 32'h1, 0, 0, 0, 4'b0010,
             1, 10, 32'h77, 1, 9, 32'h99, 32'h10, 32'h99, 32'h99, 4'b0010};
    v[6] = '{"invalid_mask", 0, 3'b100, 1, 2, 6, 32'h5, 32'h6, 0, 0, 0, 4'b1111,
             0, 0, 0, 0, 0, 0, 32'h5, 32'h6, 32'h6, 4'b0000};

    // reset with a live-looking instruction on ID
    set_id(1, 3'b111, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h3, 0, 0, 4'hF);
    rst_n = 0;
    tick;
    id_valid = 0;
    #1;
    chk("rst_valid", ex_valid, 0);
    chk("rst_ctl", ex_ctl, 0);
    chk("rst_cnt", stall_cnt, 0);
    chk("rst_stall", load_stall, 0);
    rst_n = 1;

    for (int i = 0; i < 7; i++) begin
      set_id(v[i].valid, v[i].aluctr, v[i].rs, v[i].rt, v[i].rd, v[i].rsv, v[i].rtv,
             v[i].imm, v[i].alusrc, v[i].shsel, v[i].ctl);
      tick;
      id_valid = 0;
      set_fw(v[i].mwr, v[i].mrd, v[i].mval, v[i].wwr, v[i].wrd, v[i].wval);
      #1;
      chk({v[i].nm, "_a"}, alu_a, v[i].ea);
      chk({v[i].nm, "_b"}, alu_b, v[i].eb);
      chk({v[i].nm, "_store"}, ex_store, v[i].es);
      chk({v[i].nm, "_ctl"}, ex_ctl, v[i].ectl);
      chk({v[i].nm, "_valid"}, ex_valid, v[i].valid);
      chk({v[i].nm, "_rd"}, ex_rd, v[i].rd);
      chk({v[i].nm, "_aluctr"}, alu_ctr, v[i].aluctr);
      chk({v[i].nm, "_nostall"}, load_stall, 0);
    end

    // load-use: one stall cycle, bubble, then forwarded from MEM/WB
    lw_then_use;
    chk("lu_stall", load_stall, 1);
    tick;
    exp_cnt++;
    chk("lu_bub_valid", ex_valid, 0);
    chk("lu_bub_ctl", ex_ctl, 0);
    chk("lu_bub_a", alu_a, 0);
    chk("lu_bub_b", alu_b, 0);
    chk("lu_bub_aluctr", alu_ctr, 0);
    chk("lu_bub_stall", load_stall, 0);
    chk("lu_cnt", stall_cnt, exp_cnt);
    tick;
    id_valid = 0;
    set_fw(0, 0, 0, 1, 8, 32'hABCD);
    #1;
    chk("lu_add_valid", ex_valid, 1);
    chk("lu_add_a", alu_a, 32'hABCD);
    chk("lu_add_rd", ex_rd, 9);
    chk("lu_add_cnt", stall_cnt, exp_cnt);

    // load-use under hold: everything frozen
    lw_then_use;
    hold = 1;
    for (int k = 0; k < 3; k++) begin
      tick;
      chk("hold_stall", load_stall, 1);
      chk("hold_ctl", ex_ctl, 4'b1101);
      chk("hold_rd", ex_rd, 8);
      chk("hold_cnt", stall_cnt, exp_cnt);
    end
    hold = 0;
    tick;
    exp_cnt++;
    chk("hold_rel_valid", ex_valid, 0);
    chk("hold_rel_cnt", stall_cnt, exp_cnt);
    tick;
    id_valid = 0;
    #1;

    // three more stalls: five total saturates the 2-bit counter at 3
    for (int k = 0; k < 3; k++) begin
      lw_then_use;
      tick;
      tick;
      id_valid = 0;
      #1;
    end
    chk("sat_cnt", stall_cnt, 3);

    // flush squashes a valid instruction and does not count
    set_id(1, 3'b000, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h0, 0, 0, 4'hF);
    flush = 1;
    #1;
    chk("flush_nostall", load_stall, 0);
    tick;
    flush = 0;
    id_valid = 0;
    #1;
    chk("flush_valid", ex_valid, 0);
    chk("flush_ctl", ex_ctl, 0);
    chk("flush_cnt", stall_cnt, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
